// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, valid/ready byte FIFO feeding a baud-tick serializer
// Ports: clk/rst (async, active-high); din/din_valid/din_ready enqueue handshake (ready = not full);
//        txd serial line, idle high; rts = frame on the line or FIFO non-empty; busy = mid-frame.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       txd,
  output logic       rts,
  output logic       busy
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic txd_q, txd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [PTR_W:0] cnt_q;
  logic empty, wr, pop, tick;
  assign empty = cnt_q == '0;
  assign din_ready = cnt_q != FULL_CNT;
  assign wr = din_valid && din_ready;
  assign tick = baud_q == BAUD_MAX;
  assign txd = txd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (wr) wp_q <= wp_q + PTR_W'(1);
      if (pop) rp_q <= rp_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W + 1)'(wr) - (PTR_W + 1)'(pop);
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din;
  // pop only fires from IDLE or at the end of STOP, and only when non-empty
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE) ? '0 : tick ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:  if (!empty) begin
        pop = 1'b1;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA:  if (tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP:  if (tick) begin
        pop = !empty;
        state_d = empty ? IDLE : START;
      end
    endcase
    if (pop) shift_d = mem_q[rp_q];
  end
  // txd is registered from the next state so the start bit appears on the popping edge
  always_comb begin
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    busy  = state_q != IDLE;
    rts   = busy | !empty;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with byte scoreboard and serial-line monitor for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, txd, rts, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic trace[$];
  int mon_ph = 0;
  logic mon_act = 1'b0;
  logic [9:0] mon_bits = '0;
  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .txd(txd), .rts(rts), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // serial monitor: decodes frames at mid-bit and compares against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) mon_act = 1'b0;
    else if (!mon_act) begin
      if (!txd) begin
        mon_act = 1'b1;
        mon_ph = 0;
      end
    end else begin
      mon_ph++;
      if (mon_ph % DIV == DIV / 2) mon_bits[mon_ph / DIV] = txd;
      if (mon_ph == 9 * DIV + DIV / 2) begin
        mon_act = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_frame", longint'(mon_bits), -1);
        else chk("frame", longint'(mon_bits), longint'({1'b1, exp_q.pop_front(), 1'b0}));
      end
    end
  end
  task automatic send(input logic [7:0] b, output int e);
    logic ok;
    din = b;
    din_valid = 1'b1;
    e = -1;
    for (int t = 0; t < 300 && e < 0; t++) begin
      ok = din_ready;
      @(posedge clk);
      if (ok) begin
        e = cyc;
        exp_q.push_back(b);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (e < 0) chk("send_timeout", 0, 1);
  endtask
  task automatic run_busy(output int n, output int rts_bad);
    n = 0;
    rts_bad = 0;
    trace.delete();
    while (busy && n < 400) begin
      trace.push_back(txd);
      if (rts !== 1'b1) rts_bad++;
      n++;
      @(negedge clk);
    end
  endtask
  task automatic idle_check(input string name);
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({txd, rts, busy, din_ready} !== 4'b1001) bad++;
    end
    chk(name, bad, 0);
  endtask
  task automatic drain();
    int t = 0;
    while ((rts || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("drain_timeout", t, 0);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int e, e2, n, rb;
    int acc[6];
    logic [39:0] tr40;
    logic [9:0] f41;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_rts", rts, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 1);
    rst = 1'b0;
    idle_check("idle_100");
    send(8'h41, e);
    chk("pre_start_txd", {txd, busy}, 2'b10);
    @(negedge clk);
    chk("start_latency", {txd, busy}, 2'b01);
    run_busy(n, rb);
    chk("busy_len_41", n, 40);
    chk("rts_with_busy_41", rb, 0);
    chk("rts_drop_41", rts, 0);
    f41 = 10'b1010000010;
    for (int i = 0; i < 40; i++) tr40[i] = (i < trace.size()) ? trace[i] : 1'bx;
    for (int i = 0; i < 40; i++) chk("bits_41", tr40[i], f41[i / DIV]);
    repeat (4) @(negedge clk);
    send(8'h55, e);
    send(8'hAA, e2);
    chk("b2b_accept", e2 - e, 1);
    run_busy(n, rb);
    chk("b2b_busy_len", n, 80);
    chk("b2b_rts_high", rb, 0);
    if (trace.size() >= 41) chk("b2b_no_gap", {trace[39], trace[40]}, 2'b10);
    else chk("b2b_trace_len", trace.size(), 41);
    drain();
    for (int i = 0; i < 5; i++) send(8'(i + 1), acc[i]);
    chk("burst_full_ready", din_ready, 0);
    send(8'h06, acc[5]);
    chk("burst_consec", acc[4] - acc[0], 4);
    chk("byte6_accept", acc[5] - acc[0], 42);
    drain();
    send(8'hC3, e);
    send(8'h3C, e2);
    repeat (39) @(negedge clk);
    send(8'h12, e);
    chk("same_edge_accept", e - e2, 40);
    chk("same_edge_count", dut.cnt_q, 1);
    chk("same_edge_start", {txd, busy}, 2'b01);
    drain();
    send(8'hF0, e);
    send(8'h33, e);
    send(8'h44, e);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_rts", rts, 0);
    chk("abort_ready", din_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check("idle_after_abort");
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
